// File: rtl/txd_frame_ctrl.sv
// Frame scheduler for the BPSK transmitter: Barker preamble, encoded payload, optional guard.
// Sequencing advances on the symbol strobe; start/abort/continuous control with a completed-frame counter.
module txd_frame_ctrl #(
  parameter int unsigned BARKER_LEN  = 7,
  parameter int unsigned PAYLOAD_LEN = 50,
  parameter int unsigned GUARD_LEN   = 0,
  parameter int unsigned SEL_DELAY   = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk_sig,
  input  logic             reset_sig,
  input  logic             sym_stb,
  input  logic             start_sig,
  input  logic             cont_sig,
  input  logic             abort_sig,
  output logic             barker_en,
  output logic             encode_en,
  output logic             sel_sig,
  output logic             busy_sig,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int unsigned MAX_LEN = (BARKER_LEN > PAYLOAD_LEN)
      ? ((BARKER_LEN > GUARD_LEN) ? BARKER_LEN : GUARD_LEN)
      : ((PAYLOAD_LEN > GUARD_LEN) ? PAYLOAD_LEN : GUARD_LEN);
  localparam int unsigned SEG_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned PIPE_W = (SEL_DELAY > 0) ? SEL_DELAY : 1;

  typedef enum logic [1:0] {IDLE, PRE, PAY, GUARD} state_t;

  state_t            state_q, state_d;
  logic [SEG_W-1:0]  cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic [PIPE_W-1:0] sel_pipe_q, sel_pipe_d;
  logic              req_c, eof_c, launch_c, done_c, sel_in_c, sel_nxt_c;

  // Next-state, segment counter, pending request and select pipeline
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sel_pipe_d = sel_pipe_q;
    eof_c      = 1'b0;
    launch_c   = 1'b0;
    req_c      = pend_q | start_sig;
    sel_in_c   = (state_q == PAY) || (state_q == GUARD);

    if (sym_stb) begin
      sel_pipe_d = PIPE_W'({sel_pipe_q, sel_in_c});
      case (state_q)
        IDLE: begin
          if (req_c) begin
            state_d  = PRE;
            cnt_d    = '0;
            launch_c = 1'b1;
          end
        end
        PRE: begin
          if (cnt_q == SEG_W'(BARKER_LEN - 1)) begin
            state_d = PAY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + SEG_W'(1);
          end
        end
        PAY: begin
          if (cnt_q == SEG_W'(PAYLOAD_LEN - 1)) begin
            if (GUARD_LEN > 0) begin
              state_d = GUARD;
              cnt_d   = '0;
            end else begin
              eof_c = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + SEG_W'(1);
          end
        end
        GUARD: begin
          if (cnt_q == SEG_W'(GUARD_LEN - 1)) begin
            eof_c = 1'b1;
          end else begin
            cnt_d = cnt_q + SEG_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase

      // End of frame relaunches immediately in continuous mode or on a held request
      if (eof_c) begin
        cnt_d = '0;
        if (cont_sig || req_c) begin
          state_d  = PRE;
          launch_c = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
    end

    pend_d = launch_c ? 1'b0 : req_c;

    if (abort_sig) begin
      state_d    = IDLE;
      cnt_d      = '0;
      pend_d     = 1'b0;
      sel_pipe_d = '0;
    end

    done_c    = eof_c & ~abort_sig;
    sel_nxt_c = (state_d == PAY) || (state_d == GUARD);
  end

  // State register and registered outputs decoded from the next state
  always_ff @(posedge clk_sig) begin
    if (reset_sig) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      sel_pipe_q <= '0;
      barker_en  <= 1'b0;
      encode_en  <= 1'b0;
      sel_sig    <= 1'b0;
      busy_sig   <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      sel_pipe_q <= sel_pipe_d;
      barker_en  <= (state_d == PRE);
      encode_en  <= (state_d == PAY);
      busy_sig   <= (state_d != IDLE);
      sel_sig    <= (SEL_DELAY == 0) ? sel_nxt_c : sel_pipe_d[PIPE_W-1];
      frame_done <= done_c;
      if (done_c) frame_cnt <= frame_cnt + CNT_W'(1);
    end
  end

endmodule
